// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-programmable serial pattern detector with saturating match counter
module seq_detect_param #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8,
   parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(8'b0000_1010),
   parameter int RST_LEN = 4,
   parameter bit RST_OVL = 1'b1,
   localparam int LW = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in,
   input  logic             in_valid,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pat,
   input  logic [LW-1:0]    cfg_len,
   input  logic             cfg_ovl,
   input  logic             cnt_clr,
   output logic             out,
   output logic [CNT_W-1:0] match_cnt
);
   logic [PAT_W-1:0] hist, hist_n, pat, mask;
   logic [LW-1:0] fill, fill_n, len, len_in;
   logic ovl, match;
   always_comb begin
      hist_n = {hist[PAT_W-2:0], in};
      fill_n = (fill == LW'(PAT_W)) ? fill : fill + LW'(1);
      len_in = (cfg_len > LW'(PAT_W)) ? LW'(PAT_W) : cfg_len;
      mask = '0;
      for (int i = 0; i < PAT_W; i++) mask[i] = LW'(i) < len;
      match = in_valid && !cfg_load && len != '0 && fill_n >= len && ((hist_n ^ pat) & mask) == '0;
   end
   // fill counts only bits still eligible to form a match; load and non-overlap hits empty it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist <= '0;
         fill <= '0;
         out <= 1'b0;
         match_cnt <= '0;
         pat <= RST_PAT;
         len <= LW'(RST_LEN);
         ovl <= RST_OVL;
      end else begin
         out <= match;
         if (cfg_load) begin
            pat <= cfg_pat;
            len <= len_in;
            ovl <= cfg_ovl;
            fill <= '0;
         end else if (in_valid) begin
            hist <= hist_n;
            fill <= (match && !ovl) ? '0 : fill_n;
         end
         if (cnt_clr) match_cnt <= '0;
         else if (match && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed and random checks of seq_detect_param against a queue-based model
module tb_seq_detect_param;
   logic clk = 0, reset = 1, d_in = 0, d_valid = 0, d_load = 0, d_ovl = 0, d_clr = 0;
   logic [7:0] d_pat = 0;
   logic [3:0] d_len = 0;
   logic out_s;
   logic [3:0] cnt;
   int checks = 0, errors = 0;
   bit hist_q[$];
   logic [7:0] m_pat;
   int m_len;
   bit m_ovl, m_out;
   logic [3:0] m_cnt;

   seq_detect_param #(.PAT_W(8), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .in(d_in), .in_valid(d_valid), .cfg_load(d_load),
      .cfg_pat(d_pat), .cfg_len(d_len), .cfg_ovl(d_ovl), .cnt_clr(d_clr),
      .out(out_s), .match_cnt(cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_pat = 8'h0A; m_len = 4; m_ovl = 1; hist_q.delete(); m_out = 0; m_cnt = 0;
   endtask

   // Match = the most recent len eligible bits, newest first, equal pat[0..len-1]
   task automatic model_edge(input bit b, input bit v, input bit ld, input logic [7:0] p,
                             input int l, input bit o, input bit clr);
      bit m = 0;
      if (ld) begin
         m_pat = p; m_len = (l > 8) ? 8 : l; m_ovl = o; hist_q.delete();
      end else if (v) begin
         hist_q.push_back(b);
         if (hist_q.size() > 8) void'(hist_q.pop_front());
         if (m_len > 0 && hist_q.size() >= m_len) begin
            m = 1;
            for (int i = 0; i < m_len; i++) if (hist_q[hist_q.size()-1-i] != m_pat[i]) m = 0;
         end
         if (m && !m_ovl) hist_q.delete();
      end
      m_out = m;
      m_cnt = clr ? 4'd0 : (m && m_cnt != 4'd15) ? m_cnt + 4'd1 : m_cnt;
   endtask

   task automatic drive(input bit b, input bit v, input bit ld = 0, input logic [7:0] p = 0,
                        input int l = 0, input bit o = 0, input bit clr = 0);
      d_in = b; d_valid = v; d_load = ld; d_pat = p; d_len = 4'(l); d_ovl = o; d_clr = clr;
      @(posedge clk);
      model_edge(b, v, ld, p, l, o, clr);
      #1;
      d_valid = 0; d_load = 0; d_clr = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      model_reset();
      @(posedge clk); #1;
      checks++;
      if (out_s !== 1'b0 || cnt !== 4'd0) begin
         errors++; $display("FAIL reset out=%b cnt=%0d expected out=0 cnt=0", out_s, cnt);
      end
      reset = 0;
   endtask

   task automatic test_default();
      bit bits[6] = '{1, 0, 1, 0, 1, 0};
      foreach (bits[i]) begin
         drive(bits[i], 1);
         checks++;
         if (out_s !== m_out || cnt !== m_cnt) begin
            errors++; $display("FAIL default bit%0d out=%b cnt=%0d expected out=%b cnt=%0d", i, out_s, cnt, m_out, m_cnt);
         end
      end
      checks++;
      if (cnt !== 4'd2) begin errors++; $display("FAIL default_cnt cnt=%0d expected 2", cnt); end
   endtask

   task automatic test_nonovl();
      drive(0, 0, 1, 8'h0A, 4, 0, 1);
      for (int i = 0; i < 8; i++) begin
         drive(~i[0], 1);
         checks++;
         if (out_s !== m_out || cnt !== m_cnt) begin
            errors++; $display("FAIL nonovl bit%0d out=%b cnt=%0d expected out=%b cnt=%0d", i, out_s, cnt, m_out, m_cnt);
         end
      end
      checks++;
      if (cnt !== 4'd2) begin errors++; $display("FAIL nonovl_cnt cnt=%0d expected 2", cnt); end
   endtask

   task automatic test_gaps();
      int pulses = 0;
      drive(0, 0, 1, 8'h0A, 4, 1, 1);
      for (int i = 0; i < 4; i++) begin
         drive(~i[0], 1);
         pulses += out_s;
         checks++;
         if (out_s !== m_out) begin errors++; $display("FAIL gaps bit%0d out=%b expected %b", i, out_s, m_out); end
         if (i < 3) repeat (3) begin
            drive(0, 0);
            pulses += out_s;
            checks++;
            if (out_s !== 1'b0) begin errors++; $display("FAIL gaps_idle out=%b expected 0", out_s); end
         end
      end
      checks++;
      if (pulses != 1 || cnt !== 4'd1) begin
         errors++; $display("FAIL gaps_total pulses=%0d cnt=%0d expected 1 and 1", pulses, cnt);
      end
   endtask

   task automatic test_full();
      logic [7:0] p = 8'b1100_0011;
      int pulses = 0;
      drive(0, 0, 1, p, 8, 1, 1);
      for (int i = 7; i >= 0; i--) begin drive(p[i], 1); pulses += out_s; end
      for (int i = 7; i >= 1; i--) begin drive(p[i], 1); pulses += out_s; end
      drive(p[0], 1, 1, p, 8, 1);
      checks++;
      if (out_s !== 1'b0) begin errors++; $display("FAIL load_priority out=%b expected 0", out_s); end
      for (int i = 6; i >= 0; i--) begin
         drive(p[i], 1);
         pulses += out_s;
         checks++;
         if (out_s !== 1'b0) begin errors++; $display("FAIL fill_cleared out=%b expected 0", out_s); end
      end
      for (int i = 7; i >= 0; i--) begin drive(p[i], 1); pulses += out_s; end
      checks++;
      if (pulses != 2 || cnt !== 4'd2) begin
         errors++; $display("FAIL full_width pulses=%0d cnt=%0d expected 2 and 2", pulses, cnt);
      end
   endtask

   task automatic test_sat();
      drive(0, 0, 1, 8'h01, 1, 1, 1);
      for (int i = 0; i < 20; i++) begin
         drive(1, 1);
         checks++;
         if (out_s !== 1'b1 || cnt !== ((i < 15) ? 4'(i + 1) : 4'd15)) begin
            errors++; $display("FAIL sat cycle%0d out=%b cnt=%0d expected out=1 cnt=%0d", i, out_s, cnt, (i < 15) ? i + 1 : 15);
         end
      end
      drive(1, 1, 0, 0, 0, 0, 1);
      checks++;
      if (out_s !== 1'b1 || cnt !== 4'd0) begin
         errors++; $display("FAIL clr out=%b cnt=%0d expected out=1 cnt=0", out_s, cnt);
      end
   endtask

   task automatic test_reset_mid();
      bit bits[7] = '{1, 0, 1, 0, 1, 0, 1};
      int pulses = 0;
      reset = 1; model_reset(); #2; reset = 0;
      foreach (bits[i]) drive(bits[i], 1);
      #2 reset = 1;
      #1;
      checks++;
      if (out_s !== 1'b0 || cnt !== 4'd0) begin
         errors++; $display("FAIL reset_mid out=%b cnt=%0d expected out=0 cnt=0", out_s, cnt);
      end
      model_reset();
      #2 reset = 0;
      drive(0, 1);
      checks++;
      if (out_s !== 1'b0) begin errors++; $display("FAIL reset_history out=%b expected 0", out_s); end
      for (int i = 0; i < 4; i++) begin drive(~i[0], 1); pulses += out_s; end
      checks++;
      if (pulses != 1 || cnt !== 4'd1) begin
         errors++; $display("FAIL reset_after pulses=%0d cnt=%0d expected 1 and 1", pulses, cnt);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         bit ld = $urandom_range(0, 19) == 0;
         int l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4);
         drive($urandom_range(0, 1), $urandom_range(0, 3) != 0, ld, 8'($urandom), l,
               $urandom_range(0, 1), $urandom_range(0, 29) == 0);
         checks++;
         if (out_s !== m_out || cnt !== m_cnt) begin
            errors++; $display("FAIL random cycle%0d out=%b cnt=%0d expected out=%b cnt=%0d", i, out_s, cnt, m_out, m_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_default();
      test_nonovl();
      test_gaps();
      test_full();
      test_sat();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
